// File: rtl/ex_mac_pkg.sv
// Shared encodings and op decode for the iterative EX-stage multiply/MAC unit.
package ex_mac_pkg;

    typedef enum logic [2:0] {
        MAC_MUL    = 3'd0,
        MAC_MULH   = 3'd1,
        MAC_MULHSU = 3'd2,
        MAC_MULHU  = 3'd3,
        MAC_MADD   = 3'd4,
        MAC_MADDU  = 3'd5,
        MAC_MSUB   = 3'd6,
        MAC_MSUBU  = 3'd7
    } mac_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mac_state_e;

    // Per-op control: operand signedness, accumulate, subtract, high-half writeback.
    typedef struct packed {
        logic signed_a;
        logic signed_b;
        logic accum;
        logic sub;
        logic high;
    } mac_dec_t;

    function automatic mac_dec_t mac_decode(input mac_op_e op);
        mac_dec_t d;
        d = '0;
        unique case (op)
            MAC_MUL:    begin d.signed_a = 1'b1; d.signed_b = 1'b1; end
            MAC_MULH:   begin d.signed_a = 1'b1; d.signed_b = 1'b1; d.high = 1'b1; end
            MAC_MULHSU: begin d.signed_a = 1'b1; d.high = 1'b1; end
            MAC_MULHU:  begin d.high = 1'b1; end
            MAC_MADD:   begin d.signed_a = 1'b1; d.signed_b = 1'b1; d.accum = 1'b1; end
            MAC_MADDU:  begin d.accum = 1'b1; end
            MAC_MSUB:   begin d.signed_a = 1'b1; d.signed_b = 1'b1; d.accum = 1'b1; d.sub = 1'b1; end
            MAC_MSUBU:  begin d.accum = 1'b1; d.sub = 1'b1; end
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_mac_step.sv
// One radix-2^STEP iteration: magnitude x STEP-bit digit, shifted into place and added.
module ex_mac_step
    import ex_mac_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEP  = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic [2*XLEN-1:0] partial_i,
    input  logic [XLEN-1:0]   mcand_i,
    input  logic [STEP-1:0]   digit_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [2*XLEN-1:0] sum_o
);

    logic [2*XLEN-1:0] pp;

    // Partial product for the current digit, aligned by digit position.
    always_comb begin
        pp    = {{XLEN{1'b0}}, mcand_i} * {{(2*XLEN-STEP){1'b0}}, digit_i};
        sum_o = partial_i + (pp << (32'(cnt_i) * STEP));
    end

endmodule

// File: rtl/ex_mac_unit.sv
// Iterative multiply / multiply-accumulate unit beside the EX ALU.
module ex_mac_unit
    import ex_mac_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              cancel_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [2*XLEN-1:0] result_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              stallreq_o
);

    localparam int unsigned NSTEP = XLEN / STEP;
    localparam int unsigned CNT_W = $clog2(NSTEP + 1);

    if (XLEN % STEP != 0) begin : g_bad_step
        $error("ex_mac_unit: STEP must divide XLEN");
    end

    mac_state_e        state_q, state_d;
    mac_op_e           op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              sign_q, sign_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] partial_q, partial_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic [2*XLEN-1:0] step_sum;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] res;
    mac_dec_t          dec_in, dec_q;
    logic              neg_a, neg_b;

    ex_mac_step #(
        .XLEN  (XLEN),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .partial_i (partial_q),
        .mcand_i   (mag_a_q),
        .digit_i   (mplier_q[STEP-1:0]),
        .cnt_i     (cnt_q),
        .sum_o     (step_sum)
    );

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mag_a_d   = mag_a_q;
        mplier_d  = mplier_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        wdata_d   = wdata_q;
        prod      = '0;
        res       = '0;
        dec_in    = mac_decode(mac_op_e'(op_i));
        dec_q     = mac_decode(op_q);
        neg_a     = dec_in.signed_a & opa_i[XLEN-1];
        neg_b     = dec_in.signed_b & opb_i[XLEN-1];

        // Cancel overrides the FSM so a FIX-cycle flush never updates the result.
        if (cancel_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d   = ST_CALC;
                        op_d      = mac_op_e'(op_i);
                        mag_a_d   = neg_a ? (~opa_i + XLEN'(1)) : opa_i;
                        mplier_d  = neg_b ? (~opb_i + XLEN'(1)) : opb_i;
                        sign_d    = neg_a ^ neg_b;
                        acc_d     = acc_i;
                        partial_d = '0;
                        cnt_d     = '0;
                    end
                end
                ST_CALC: begin
                    partial_d = step_sum;
                    mplier_d  = mplier_q >> STEP;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NSTEP - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    prod = sign_q ? (~partial_q + (2*XLEN)'(1)) : partial_q;
                    if (dec_q.accum) begin
                        res = dec_q.sub ? (acc_q - prod) : (acc_q + prod);
                    end else begin
                        res = prod;
                    end
                    result_d = res;
                    wdata_d  = dec_q.high ? res[2*XLEN-1:XLEN] : res[XLEN-1:0];
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_o     = (state_q != ST_IDLE);
        ready_o    = (state_q == ST_DONE);
        stallreq_o = (start_i & (state_q == ST_IDLE)) | (state_q == ST_CALC) | (state_q == ST_FIX);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MAC_MUL;
            mag_a_q   <= '0;
            mplier_q  <= '0;
            sign_q    <= 1'b0;
            acc_q     <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mag_a_q   <= mag_a_d;
            mplier_q  <= mplier_d;
            sign_q    <= sign_d;
            acc_q     <= acc_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            wdata_q   <= wdata_d;
        end
    end

    assign result_o = result_q;
    assign wdata_o  = wdata_q;

endmodule

// File: tb/tb_ex_mac_unit.sv
// Self-checking bench for ex_mac_unit: scoreboarded ops, cancel/reset, STEP variants.
module tb_ex_mac_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, start_v, cancel_i;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i;
    logic [63:0] acc_i;

    logic        busy_o, ready_o, stallreq_o;
    logic [63:0] result_o;
    logic [31:0] wdata_o;

    logic        busy_s1, ready_s1, stall_s1;
    logic [63:0] result_s1;
    logic [31:0] wdata_s1;
    logic        busy_s8, ready_s8, stall_s8;
    logic [63:0] result_s8;
    logic [31:0] wdata_s8;

    typedef struct {
        logic [63:0] res;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    ex_mac_unit #(.XLEN(32), .STEP(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cancel_i(cancel_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .acc_i(acc_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    ex_mac_unit #(.XLEN(32), .STEP(1)) dut_s1 (
        .clk(clk), .rst(rst), .start_i(start_v), .cancel_i(cancel_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .acc_i(acc_i), .busy_o(busy_s1), .ready_o(ready_s1),
        .result_o(result_s1), .wdata_o(wdata_s1), .stallreq_o(stall_s1)
    );

    ex_mac_unit #(.XLEN(32), .STEP(8)) dut_s8 (
        .clk(clk), .rst(rst), .start_i(start_v), .cancel_i(cancel_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .acc_i(acc_i), .busy_o(busy_s8), .ready_o(ready_s8),
        .result_o(result_s8), .wdata_o(wdata_s8), .stallreq_o(stall_s8)
    );

    // Reference: sign/zero-extend both operands to 64 bits and multiply modulo 2^64.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [63:0] acc);
        exp_t        e;
        logic        sa, sb_;
        logic [63:0] ae, be, p;
        sa  = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sb_ = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        ae  = sa  ? {{32{a[31]}}, a} : {32'h0, a};
        be  = sb_ ? {{32{b[31]}}, b} : {32'h0, b};
        p   = ae * be;
        if (op == 3'd4 || op == 3'd5)      e.res = acc + p;
        else if (op == 3'd6 || op == 3'd7) e.res = acc - p;
        else                               e.res = p;
        e.wd = (op >= 3'd1 && op <= 3'd3) ? e.res[63:32] : e.res[31:0];
        return e;
    endfunction

    // Issue one op (entered and left at posedge+1), check latency, stall window and scoreboard.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] acc,
                         input logic [63:0] eres, input logic [31:0] ewd);
        exp_t e, got_e;
        int   cyc, stall_cnt;
        bit   got;
        e.res = eres;
        e.wd  = ewd;
        sb.push_back(e);
        op_i = op; opa_i = a; opb_i = b; acc_i = acc;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 1; got = 0; stall_cnt = 0;
        while (!got && cyc <= 40) begin
            if (ready_o) got = 1;
            else begin
                if (stallreq_o) stall_cnt++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        got_e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no ready_o within 40 cycles, want one at 10", name);
        end else begin
            checks++;
            if (cyc !== 10) begin
                errors++;
                $display("FAIL %s latency: got %0d want 10", name, cyc);
            end
            checks++;
            if (stall_cnt !== 9 || stallreq_o !== 1'b0) begin
                errors++;
                $display("FAIL %s stallreq: high %0d cycles, at ready %b; want 9 and 0", name, stall_cnt, stallreq_o);
            end
            checks++;
            if (result_o !== got_e.res) begin
                errors++;
                $display("FAIL %s result: got %h want %h", name, result_o, got_e.res);
            end
            checks++;
            if (wdata_o !== got_e.wd) begin
                errors++;
                $display("FAIL %s wdata: got %h want %h", name, wdata_o, got_e.wd);
            end
        end
        last_res = got_e.res;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: ready %b busy %b, want 0 0", name, ready_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; start_v = 1'b0; cancel_i = 1'b0;
        op_i = '0; opa_i = '0; opb_i = '0; acc_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy_o, ready_o, stallreq_o} !== 3'b000 || result_o !== 64'h0 || wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy %b ready %b stall %b result %h wdata %h, want all 0",
                     busy_o, ready_o, stallreq_o, result_o, wdata_o);
        end
    endtask

    task automatic test_mul_latency();
        do_op("mul_neg", 3'd0, 32'hFFFFFFFF, 32'h2, 64'h0, 64'hFFFFFFFF_FFFFFFFE, 32'hFFFFFFFE);
    endtask

    task automatic test_mulh_variants();
        do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001, 32'hFFFFFFFE);
        do_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'h00000000_00000001, 32'h00000000);
        do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFF_00000001, 32'hFFFFFFFF);
        do_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 64'h0, 64'h40000000_00000000, 32'h40000000);
    endtask

    task automatic test_accumulate();
        do_op("madd",  3'd4, 32'h3, 32'hFFFFFFFE, 64'h10, 64'hA, 32'hA);
        do_op("msubu", 3'd7, 32'h00010000, 32'h00010000, 64'h0000000100000000, 64'h0, 32'h0);
        do_op("msub",  3'd6, 32'hFFFFFFFD, 32'h5, 64'h1, 64'h10, 32'h10);
    endtask

    task automatic test_cancel();
        logic [63:0] prev;
        bit          saw_ready;
        prev = last_res;
        op_i = 3'd0; opa_i = 32'd5; opb_i = 32'd5; acc_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle: busy %b ready %b stall %b, want 0 0 0", busy_o, ready_o, stallreq_o);
        end
        saw_ready = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ready_o) saw_ready = 1;
        end
        checks++;
        if (saw_ready || result_o !== prev) begin
            errors++;
            $display("FAIL cancel_hold: ready seen %b result %h, want 0 and %h", saw_ready, result_o, prev);
        end
        do_op("mul_after_cancel", 3'd0, 32'd7, 32'd6, 64'h0, 64'd42, 32'd42);
    endtask

    task automatic test_start_while_busy();
        int n_ready, first_cyc;
        op_i = 3'd0; opa_i = 32'h1234; opb_i = 32'h10; acc_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_ready = 0; first_cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            if (ready_o) begin
                n_ready++;
                if (first_cyc == 0) first_cyc = c;
            end
            start_i = (c == 3 || c == 6 || c == 10);
            opa_i   = 32'd99;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        checks++;
        if (n_ready !== 1 || first_cyc !== 10) begin
            errors++;
            $display("FAIL busy_start: ready count %0d at cycle %0d, want 1 at 10", n_ready, first_cyc);
        end
        checks++;
        if (result_o !== 64'h12340 || wdata_o !== 32'h12340) begin
            errors++;
            $display("FAIL busy_start_result: got %h/%h want 0000000000012340/00012340", result_o, wdata_o);
        end
        last_res = 64'h12340;
    endtask

    task automatic test_reset_mid();
        bit saw_ready;
        op_i = 3'd3; opa_i = 32'hDEADBEEF; opb_i = 32'h12345678; acc_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy_o, ready_o, stallreq_o} !== 3'b000 || result_o !== 64'h0 || wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy %b ready %b stall %b result %h wdata %h, want all 0",
                     busy_o, ready_o, stallreq_o, result_o, wdata_o);
        end
        saw_ready = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (ready_o) saw_ready = 1;
        end
        checks++;
        if (saw_ready) begin
            errors++;
            $display("FAIL reset_mid_ready: ready seen %b want 0", saw_ready);
        end
        last_res = 64'h0;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] acc;
        for (int i = 0; i < 16; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = (i % 5 == 0) ? 32'h80000000 : $urandom;
            b   = (i % 7 == 3) ? 32'h0 : $urandom;
            acc = {$urandom, $urandom};
            e   = model(op, a, b, acc);
            do_op($sformatf("b2b%0d_op%0d", i, op), op, a, b, acc, e.res, e.wd);
        end
    endtask

    task automatic test_step_variants();
        exp_t        e;
        int          lat1, lat8;
        logic [2:0]  ops[2];
        logic [31:0] as[2], bs[2];
        ops[0] = 3'd6; as[0] = 32'h89ABCDEF; bs[0] = 32'hF0F0F0F1;
        ops[1] = 3'd2; as[1] = 32'h80000001; bs[1] = 32'hFEDCBA98;
        for (int k = 0; k < 2; k++) begin
            op_i = ops[k]; opa_i = as[k]; opb_i = bs[k]; acc_i = 64'h0123456789ABCDEF;
            e = model(ops[k], as[k], bs[k], 64'h0123456789ABCDEF);
            start_v = 1'b1;
            @(posedge clk); #1;
            start_v = 1'b0;
            lat1 = 0; lat8 = 0;
            for (int c = 1; c <= 45 && (lat1 == 0 || lat8 == 0); c++) begin
                if (ready_s1 && lat1 == 0) lat1 = c;
                if (ready_s8 && lat8 == 0) lat8 = c;
                if (lat1 == 0 || lat8 == 0) begin @(posedge clk); #1; end
            end
            checks++;
            if (lat1 !== 34 || lat8 !== 6) begin
                errors++;
                $display("FAIL step_latency%0d: step1 %0d step8 %0d, want 34 and 6 (0 = none)", k, lat1, lat8);
            end
            checks++;
            if (result_s1 !== e.res || result_s8 !== e.res || wdata_s1 !== e.wd || wdata_s8 !== e.wd) begin
                errors++;
                $display("FAIL step_result%0d: s1 %h/%h s8 %h/%h want %h/%h",
                         k, result_s1, wdata_s1, result_s8, wdata_s8, e.res, e.wd);
            end
            repeat (2) begin @(posedge clk); #1; end
            checks++;
            if ({busy_s1, busy_s8, stall_s1, stall_s8} !== 4'b0000) begin
                errors++;
                $display("FAIL step_idle%0d: busy %b%b stall %b%b want 0000", k, busy_s1, busy_s8, stall_s1, stall_s8);
            end
        end
    endtask

    initial begin
        last_res = '0;
        test_reset();
        test_mul_latency();
        test_mulh_variants();
        test_accumulate();
        test_cancel();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_step_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
